access_phase_s: RTL and testbench
=================================

Name: access_phase_s

Overview:
- Passive APB phase tracker and protocol checker.
- Sits beside an APB bus, on the requester-to-completer link, and never drives the bus.
- Decodes the SETUP, ACCESS and transfer-complete phases.
- Flags APB protocol violations as one-cycle pulses and as sticky status bits; the status feeds the verification environment or a debug register block.

Parameters:
- ADDR_WIDTH, default 16: width of paddr.
- DATA_WIDTH, default 32: width of pwdata and prdata.
- TIMEOUT_CYCLES, default 16: wait-state limit. Used only when ACCESS_PHASE_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- pclk, in, 1: APB clock. All state updates on the rising edge.
- preset_n, in, 1: reset, asynchronous and active-low.
- psel, in, 1: APB select.
- penable, in, 1: APB enable.
- pwrite, in, 1: APB direction, 1 = write.
- paddr, in, ADDR_WIDTH: APB address.
- pwdata, in, DATA_WIDTH: APB write data.
- pready, in, 1: completer ready.
- prdata, in, DATA_WIDTH: read data. Monitored only; no check uses it.
- pslverr, in, 1: completer error. Monitored only; no check uses it.
- chk_en, in, 1: checking enable. 0 suppresses all error detection.
- err_clr, in, 1: synchronous clear of err_sticky.
- setup_phase, out, 1: current cycle is the SETUP phase (combinational).
- access_phase, out, 1: current cycle is the ACCESS phase (combinational).
- xfer_done, out, 1: transfer completes this cycle (combinational).
- err_pulse, out, 7: per-check violation pulse (registered).
- err_sticky, out, 7: per-check sticky violation flags (registered).
- err_any, out, 1: OR of err_sticky.

Behaviour:

History registers, reset to 0:
- psel_q, pready_q, pwrite_q, paddr_q, pwdata_q: previous-cycle sample of each input.
- setup_q: previous setup_phase.
- done_q: previous (access_phase && pready).
- History registers update every cycle, regardless of chk_en.

Phase decode:
- setup_phase = psel && (!psel_q || (psel_q && pready_q)).
- access_phase = psel && penable.
- xfer_done = access_phase && pready.

Checks. Each is evaluated combinationally on the current sample and is masked by chk_en:
- bit0: setup_phase && penable (PENABLE high in SETUP).
- bit1: setup_q && !penable (PENABLE failed to rise entering ACCESS).
- bit2: done_q && penable (PENABLE failed to fall after completion).
- bit3: access_phase && (pwrite != pwrite_q).
- bit4: access_phase && (paddr != paddr_q).
- bit5: access_phase && pwrite && (pwdata != pwdata_q).
- bit6: wait-state timeout. Tied to 0 unless ACCESS_PHASE_TIMEOUT_EN is defined.

Error outputs:
- err_pulse is registered: a violation sampled at edge N appears on err_pulse for exactly the cycle after edge N (latency 1).
- err_sticky bit sets on the same edge as its err_pulse bit and holds until err_clr.
- When err_clr and a new violation occur on the same edge, set wins.
- err_any is combinational from err_sticky.

Reset:
- preset_n low immediately clears all registers: err_pulse=0, err_sticky=0, err_any=0.
- With psel_q=0 cleared, setup_phase follows psel during reset.
- On reset release, history starts from 0. A transfer begun on the first cycle after reset is therefore a valid SETUP.
- Reset mid-transfer discards the transfer, with no error.

chk_en:
- chk_en=0 blocks new pulses and sticky sets.
- Existing sticky bits are retained.

Back-to-back transfers:
- psel held high across a completion starts a new SETUP on the next cycle, because psel_q && pready_q is true.

Optional Feature:
- Macro: ACCESS_PHASE_TIMEOUT_EN.
- Defined: an 8-bit wait counter runs as follows.
  - It increments each cycle that access_phase && !pready holds.
  - It clears when !access_phase or on xfer_done.
  - It saturates at TIMEOUT_CYCLES.
  - Bit6 fires once, the cycle the counter first reaches TIMEOUT_CYCLES, masked by chk_en.
  - It does not fire again until the counter clears.
- Not defined: no counter logic is present and bit6 is constant 0.

Test Plan:
1. Write to paddr=0x0010, pwdata=0xA5A5_5A5A, 0 wait states: setup_phase=1 in cycle 1; access_phase=1 and xfer_done=1 in cycle 2; err_sticky=0 throughout.
2. Read with 3 wait states while paddr changes 0x0010 to 0x0014 in the second ACCESS cycle: err_pulse[4]=1 for one cycle on the next cycle; err_sticky[4] stays 1; err_any=1; err_clr=1 for one cycle then clears it to 0.
3. psel=1 and penable=1 in the SETUP cycle gives err_pulse[0]. Repeating the same stimulus with chk_en=0 gives no pulse and no sticky change.
4. SETUP followed by penable=0 gives bit1. After a completion, penable held 1 with psel=1 gives bit2. A write whose pwdata changes from 0x1 to 0x2 during ACCESS gives bit5.
5. Back-to-back writes with psel held high: setup_phase=1 the cycle after each xfer_done; no errors.
6. With ACCESS_PHASE_TIMEOUT_EN and TIMEOUT_CYCLES=4, 6 wait states: err_pulse[6] fires exactly once after the 4th wait cycle. Asserting preset_n low mid-ACCESS clears all outputs to 0 immediately.

Source files
------------

// File: rtl/access_phase_s_if.sv
`default_nettype none
// ============================================================================
// Module      : access_phase_s_if
// Description : APB requester-to-completer bus bundle. The master and slave
//               modports describe the two bus agents; the monitor modport is
//               a listen-only view used by passive observers.
// Revision    : 1.0  initial release
// ============================================================================
interface access_phase_s_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

  modport monitor (
    input psel, penable, pwrite, paddr, pwdata,
    input pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/access_phase_s.sv
`default_nettype none
// ============================================================================
// Module      : access_phase_s
// Description : Passive APB phase tracker and protocol checker. Decodes the
//               SETUP / ACCESS / completion phases and reports protocol
//               violations as one-cycle pulses and sticky flags.
//               Optional macro ACCESS_PHASE_TIMEOUT_EN enables the wait-state
//               timeout check (err bit 6).
// Revision    : 1.0  initial release
// ============================================================================
module access_phase_s #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic            pclk,
  input  wire logic            preset_n,
  access_phase_s_if.monitor    apb,
  input  wire logic            chk_en,
  input  wire logic            err_clr,
  output logic                 setup_phase,
  output logic                 access_phase,
  output logic                 xfer_done,
  output logic [6:0]           err_pulse,
  output logic [6:0]           err_sticky,
  output logic                 err_any
);

  // Previous-cycle view of the bus
  logic                  psel_q;
  logic                  pready_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  setup_q;
  logic                  done_q;

  logic [6:0]            viol;
  logic [6:0]            err_new;
  logic                  timeout_hit;

  // Read data and error response are observed but never checked
  logic unused_monitor;
  assign unused_monitor = ^{apb.prdata, apb.pslverr};

  // A new SETUP starts when select rises, or when select stays high across
  // a completed transfer (back-to-back).
  assign setup_phase  = apb.psel && (!psel_q || (psel_q && pready_q));
  assign access_phase = apb.psel && apb.penable;
  assign xfer_done    = access_phase && apb.pready;
  assign err_any      = |err_sticky;

  // History registers track every cycle, independent of checking enable
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel_q   <= 1'b0;
      pready_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      setup_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      psel_q   <= apb.psel;
      pready_q <= apb.pready;
      pwrite_q <= apb.pwrite;
      paddr_q  <= apb.paddr;
      pwdata_q <= apb.pwdata;
      setup_q  <= setup_phase;
      done_q   <= xfer_done;
    end
  end

`ifdef ACCESS_PHASE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_MAX  = 8'(TIMEOUT_CYCLES);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;

  // Saturating count of consecutive wait states in the current ACCESS
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= 8'd0;
    end else if (!access_phase || apb.pready) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != TIMEOUT_MAX) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fires only on the wait cycle that carries the count up to the limit
  assign timeout_hit = access_phase && !apb.pready && (wait_cnt == TIMEOUT_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Evaluate all protocol checks on the current sample
  always_comb begin
    viol    = '0;
    viol[0] = setup_phase && apb.penable;
    viol[1] = setup_q && !apb.penable;
    viol[2] = done_q && apb.penable;
    viol[3] = access_phase && (apb.pwrite != pwrite_q);
    viol[4] = access_phase && (apb.paddr != paddr_q);
    viol[5] = access_phase && apb.pwrite && (apb.pwdata != pwdata_q);
    viol[6] = timeout_hit;
    err_new = chk_en ? viol : 7'd0;
  end

  // Register pulses; sticky flags set on the same edge, set beats clear
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      err_pulse  <= 7'd0;
      err_sticky <= 7'd0;
    end else begin
      err_pulse  <= err_new;
      err_sticky <= (err_clr ? 7'd0 : err_sticky) | err_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_access_phase_s.sv
`default_nettype none
// ============================================================================
// Module      : tb_access_phase_s
// Description : Self-checking bench for access_phase_s. A stimulus process
//               drives one bus cycle per falling edge and pushes the expected
//               observation from a behavioural model into a queue; a monitor
//               pops and compares two time units later each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_access_phase_s;

`ifdef ACCESS_PHASE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  typedef struct {
    logic [2:0] phase;   // {setup, access, done}
    logic [6:0] pulse;
    logic [6:0] sticky;
    logic       any;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        chk_en = 1'b1;
  logic        err_clr = 1'b0;
  logic        setup_phase, access_phase, xfer_done, err_any;
  logic [6:0]  err_pulse, err_sticky;

  access_phase_s_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  access_phase_s #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .apb          (bus),
    .chk_en       (chk_en),
    .err_clr      (err_clr),
    .setup_phase  (setup_phase),
    .access_phase (access_phase),
    .xfer_done    (xfer_done),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .err_any      (err_any)
  );

  always #5 pclk = ~pclk;

  // Reference model: what the checker remembers from the previous cycle
  bit          m_psel, m_rdy, m_wr, m_setup, m_done;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  int          m_waits;
  logic [6:0]  m_pulse, m_sticky;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  bit          stim_done = 1'b0;

  task automatic model_zero();
    m_psel = 0; m_rdy = 0; m_wr = 0; m_setup = 0; m_done = 0;
    m_addr = '0; m_data = '0; m_waits = 0; m_pulse = '0; m_sticky = '0;
  endtask

  // One bus cycle: drive, predict, and advance the model through the edge
  task automatic cyc(input bit ps, input bit pe, input bit pw, input logic [15:0] a,
                     input logic [31:0] d, input bit rdy, input bit ce = 1,
                     input bit clr = 0, input bit rn = 1);
    exp_t e;
    bit setup, acc, done;
    int nwaits;
    logic [6:0] v;
    @(negedge pclk);
    bus.psel = ps; bus.penable = pe; bus.pwrite = pw; bus.paddr = a;
    bus.pwdata = d; bus.pready = rdy; bus.prdata = $urandom; bus.pslverr = $urandom_range(0, 1) == 1;
    chk_en = ce; err_clr = clr; preset_n = rn;
    if (!rn) model_zero();
    setup = ps && (!m_psel || m_rdy);
    acc   = ps && pe;
    done  = acc && rdy;
    nwaits = (acc && !rdy) ? m_waits + 1 : 0;
    v = '0;
    v[0] = setup && pe;
    v[1] = m_setup && !pe;
    v[2] = m_done && pe;
    v[3] = acc && (pw != m_wr);
    v[4] = acc && (a != m_addr);
    v[5] = acc && pw && (d != m_data);
`ifdef ACCESS_PHASE_TIMEOUT_EN
    v[6] = (nwaits == TO);
`endif
    if (!ce) v = '0;
    e.phase = {setup, acc, done};
    e.pulse = m_pulse; e.sticky = m_sticky; e.any = |m_sticky;
    sb.push_back(e);
    if (rn) begin
      m_pulse  = v;
      m_sticky = (clr ? 7'd0 : m_sticky) | v;
      m_psel = ps; m_rdy = rdy; m_wr = pw; m_addr = a; m_data = d;
      m_setup = setup; m_done = done; m_waits = nwaits;
    end
  endtask

  task automatic idle(input int n = 1, input bit clr = 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 32'h0, 0, 1, clr);
  endtask

  // Legal transfer: SETUP, wait states, completing ACCESS
  task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] d,
                      input int waits, input bit ce = 1);
    cyc(1, 0, w, a, d, 0, ce);
    for (int i = 0; i < waits; i++) cyc(1, 1, w, a, d, 0, ce);
    cyc(1, 1, w, a, d, 1, ce);
  endtask

  // Monitor: compare each presented cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cycle++;
        total++;
        if ({setup_phase, access_phase, xfer_done} !== e.phase) begin
          bad++;
          $display("FAIL cyc=%0d phase got=%b exp=%b", cycle,
                   {setup_phase, access_phase, xfer_done}, e.phase);
        end
        total++;
        if ({err_pulse, err_sticky, err_any} !== {e.pulse, e.sticky, e.any}) begin
          bad++;
          $display("FAIL cyc=%0d err pulse/sticky/any got=%h/%h/%b exp=%h/%h/%b", cycle,
                   err_pulse, err_sticky, err_any, e.pulse, e.sticky, e.any);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0;
    bus.pwdata = '0; bus.pready = 0; bus.prdata = '0; bus.pslverr = 0;
    model_zero();
    // Reset state; SETUP follows psel while held in reset
    cyc(0, 0, 0, 16'h0, 32'h0, 0, 1, 0, 0);
    cyc(1, 0, 1, 16'h0, 32'h0, 0, 1, 0, 0);
    cyc(0, 0, 0, 16'h0, 32'h0, 0, 1, 0, 0);
    // Write straight after reset release, no wait states
    xfer(1, 16'h0010, 32'hA5A5_5A5A, 0);
    idle(1);
    // Read, 3 waits, address moves in the second ACCESS cycle
    cyc(1, 0, 0, 16'h0010, 32'h0, 0);
    cyc(1, 1, 0, 16'h0010, 32'h0, 0);
    cyc(1, 1, 0, 16'h0014, 32'h0, 0);
    cyc(1, 1, 0, 16'h0014, 32'h0, 0);
    cyc(1, 1, 0, 16'h0014, 32'h0, 1);
    idle(2);
    idle(1, 1);
    idle(1);
    // PENABLE high in SETUP, checked then unchecked
    cyc(1, 1, 1, 16'h0020, 32'h1, 0);
    cyc(1, 1, 1, 16'h0020, 32'h1, 1);
    idle(1); idle(1, 1);
    cyc(1, 1, 1, 16'h0020, 32'h1, 0, 0);
    cyc(1, 1, 1, 16'h0020, 32'h1, 1, 0);
    idle(2);
    // PENABLE fails to rise
    cyc(1, 0, 1, 16'h0030, 32'h1, 0);
    cyc(1, 0, 1, 16'h0030, 32'h1, 0);
    idle(1, 1);
    // PENABLE fails to fall after completion
    xfer(1, 16'h0030, 32'h1, 0);
    cyc(1, 1, 1, 16'h0030, 32'h1, 0);
    idle(1, 1);
    // Write data changes during ACCESS
    cyc(1, 0, 1, 16'h0040, 32'h1, 0);
    cyc(1, 1, 1, 16'h0040, 32'h2, 1);
    idle(2);
    // Clear and new violation on the same edge: set wins
    cyc(1, 1, 0, 16'h0040, 32'h0, 0, 1, 1);
    idle(1, 1);
    // Back-to-back writes with psel held high
    xfer(1, 16'h0050, 32'h11, 0);
    xfer(1, 16'h0054, 32'h22, 1);
    xfer(1, 16'h0058, 32'h33, 0);
    idle(1);
    // Long wait: timeout when enabled, then reset mid-ACCESS
    xfer(0, 16'h0060, 32'h0, 6);
    cyc(1, 1, 1, 16'h0070, 32'h5, 0);
    cyc(1, 0, 1, 16'h0070, 32'h5, 0);
    cyc(1, 1, 1, 16'h0070, 32'h5, 0);
    cyc(1, 1, 1, 16'h0070, 32'h5, 0, 1, 0, 0);
    idle(2);
    // Randomized mix of legal transfers and arbitrary bus cycles
    for (int n = 0; n < 1500; n++) begin
      int mode;
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            16'h0010 + 16'($urandom_range(0, 1) * 4), 32'($urandom_range(1, 2)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
      end else begin
        xfer($urandom_range(0, 1) == 1, 16'($urandom_range(0, 3) * 4), 32'($urandom_range(1, 2)),
             $urandom_range(0, 6), $urandom_range(0, 7) != 0);
        if ($urandom_range(0, 1) == 1) idle(1, $urandom_range(0, 4) == 0);
      end
    end
    idle(3);
    stim_done = 1'b1;
    @(negedge pclk);
    #4;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard residue got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Runaway guard
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired stim_done got=%0b exp=1", stim_done);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
